// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and helpers for the data-memory arbiter
package dmem_arb_pkg;

    // Arbiter FSM: normal CPU ownership, or the cycle after a host grant
    typedef enum logic {
        S_CPU = 1'b0,
        S_ACK = 1'b1
    } arb_state_t;

    // Which requester currently drives the dataMem port
    typedef enum logic {
        SEL_CPU  = 1'b0,
        SEL_HOST = 1'b1
    } mem_sel_e;

    // Width of the host wait counter; a counter that only ever holds 0 still needs one bit
    function automatic int wait_cnt_width(input int max_wait);
        int w;
        w = $clog2(max_wait + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, host and dataMem signal bundle for the arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // MEM-stage side
    logic              cpu_re;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Host/debug side
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    // dataMem side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    // Requester/memory environment view
    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating count of cycles the host has lost to the CPU
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = wait_cnt_width(MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; increment stops at MAX
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/host data-memory arbiter with bounded host wait; DMEM_ARB_STATS_EN adds counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int HOST_WAIT_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]      stat_stall_cycles,
    output logic [31:0]      stat_host_xfers
`endif
);
    arb_state_t        state_q;
    logic              host_ack_q;
    logic [DATA_W-1:0] host_rdata_q;

    logic              cpu_req;
    logic              at_max;
    logic              host_pick;
    logic              cpu_stall;
    logic              cnt_clr;
    logic              cnt_inc;
    mem_sel_e          mem_sel;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_re;

    assign cpu_req = bus.cpu_re | bus.cpu_we;

    // The host only wins in S_CPU, and only when the CPU is idle or has starved it long enough
    assign host_pick = (state_q == S_CPU) & bus.host_req & (~cpu_req | at_max);
    assign mem_sel   = host_pick ? SEL_HOST : SEL_CPU;
    assign cpu_stall = host_pick & cpu_req;

    // A pending host loses a cycle whenever the CPU keeps the port; a grant or a dropped request restarts the wait
    assign cnt_clr = host_pick | ~bus.host_req;
    assign cnt_inc = bus.host_req & cpu_req;

    arb_wait_counter #(
        .MAX (HOST_WAIT_MAX)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .at_max_o (at_max)
    );

    // dataMem port mux; idle cycles pass the CPU inputs so the enables stay low
    always_comb begin
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        sel_we    = bus.cpu_we;
        sel_re    = bus.cpu_re;
        case (mem_sel)
            SEL_HOST: begin
                sel_addr  = bus.host_addr;
                sel_wdata = bus.host_wdata;
                sel_we    = bus.host_we;
                sel_re    = ~bus.host_we;
            end
            default: ;
        endcase
    end

    // Grant/ack FSM with registered ack pulse and captured host read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_CPU;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            case (state_q)
                S_CPU: begin
                    if (host_pick) begin
                        state_q    <= S_ACK;
                        host_ack_q <= 1'b1;
                        if (!bus.host_we) begin
                            host_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        host_ack_q <= 1'b0;
                    end
                end
                S_ACK: begin
                    state_q    <= S_CPU;
                    host_ack_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_CPU;
                    host_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;
    assign bus.mem_we     = sel_we;
    assign bus.mem_re     = sel_re;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = cpu_stall;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] xfer_cnt_q;

    // Free-running stall and completed-transfer counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            if (cpu_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (host_ack_q) begin
                xfer_cnt_q <= xfer_cnt_q + 32'd1;
            end
        end
    end

    assign stat_stall_cycles = stall_cnt_q;
    assign stat_host_xfers   = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with HOST_WAIT_MAX of 4 and 0
module tb_dmem_arbiter;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } host_exp_t;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic mem_init = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    host_exp_t   host_q4[$];
    host_exp_t   host_q0[$];
    logic [31:0] cpu_q4[$];
    logic [31:0] cpu_q0[$];

    logic [31:0] exp4 [256];
    logic [31:0] exp0 [256];
    logic [31:0] ram4 [256];
    logic [31:0] ram0 [256];

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall4, xfer4, stall0, xfer0;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        return 32'hA500_0000 + 32'(a) * 32'h0000_0103;
    endfunction

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if4 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .HOST_WAIT_MAX(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_stall_cycles (stall4),
        .stat_host_xfers   (xfer4)
`endif
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .HOST_WAIT_MAX(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_stall_cycles (stall0),
        .stat_host_xfers   (xfer0)
`endif
    );

    // dataMem models: combinational read, synchronous write
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram4[i] <= init_val(i);
        end else if (if4.mem_we) begin
            ram4[if4.mem_addr[7:0]] <= if4.mem_wdata;
        end
    end
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram0[i] <= init_val(i);
        end else if (if0.mem_we) begin
            ram0[if0.mem_addr[7:0]] <= if0.mem_wdata;
        end
    end
    assign if4.mem_rdata = ram4[if4.mem_addr[7:0]];
    assign if0.mem_rdata = ram0[if0.mem_addr[7:0]];

    task automatic idle_all();
        if4.cpu_re = 0; if4.cpu_we = 0; if4.cpu_addr = 0; if4.cpu_wdata = 0;
        if4.host_req = 0; if4.host_we = 0; if4.host_addr = 0; if4.host_wdata = 0;
        if0.cpu_re = 0; if0.cpu_we = 0; if0.cpu_addr = 0; if0.cpu_wdata = 0;
        if0.host_req = 0; if0.host_we = 0; if0.host_addr = 0; if0.host_wdata = 0;
    endtask

    task automatic test_reset();
        reset = 0; mem_init = 1;
        idle_all();
        if4.cpu_re = 1; if4.cpu_addr = 32'h24;
        @(posedge clk); #1; mem_init = 0;
        @(negedge clk);
        vectors++; if (if4.host_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", if4.host_ack); end
        vectors++; if (if4.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", if4.cpu_stall); end
        vectors++; if (if4.host_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", if4.host_rdata); end
        vectors++; if (if4.mem_re !== 1'b1 || if4.mem_addr !== 32'h24) begin miscompares++; $display("FAIL reset_mem_follow: got re=%b addr=%h want re=1 addr=24", if4.mem_re, if4.mem_addr); end
        vectors++; if (if0.host_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack0: got %b want 0", if0.host_ack); end
        @(posedge clk); #1; reset = 1; if4.cpu_re = 0;
        @(negedge clk);
        vectors++; if (if4.mem_re !== 1'b0 || if4.mem_we !== 1'b0) begin miscompares++; $display("FAIL idle_mem: got re=%b we=%b want 0 0", if4.mem_re, if4.mem_we); end
    endtask

    // One host access on the WAIT_MAX=4 arbiter with the CPU idle
    task automatic host_xfer4(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        host_exp_t e;
        host_exp_t got;
        @(posedge clk); #1;
        if4.host_req = 1; if4.host_we = we; if4.host_addr = addr; if4.host_wdata = wdata;
        e.is_read = !we;
        e.data    = we ? 32'h0 : exp4[addr[7:0]];
        host_q4.push_back(e);
        if (we) exp4[addr[7:0]] = wdata;
        @(negedge clk);
        vectors++; if (if4.mem_we !== we || if4.mem_re !== !we || if4.mem_addr !== addr) begin miscompares++; $display("FAIL %s_grant: got we=%b re=%b addr=%h want we=%b addr=%h", tag, if4.mem_we, if4.mem_re, if4.mem_addr, we, addr); end
        vectors++; if (we && if4.mem_wdata !== wdata) begin miscompares++; $display("FAIL %s_wdata: got %h want %h", tag, if4.mem_wdata, wdata); end
        vectors++; if (if4.cpu_stall !== 1'b0 || if4.host_ack !== 1'b0) begin miscompares++; $display("FAIL %s_grant_flags: got stall=%b ack=%b want 0 0", tag, if4.cpu_stall, if4.host_ack); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (if4.host_ack !== 1'b1) begin
            miscompares++; $display("FAIL %s_ack: got %b want 1", tag, if4.host_ack);
        end else if (host_q4.size() == 0) begin
            miscompares++; $display("FAIL %s_scoreboard: got ack with empty queue want queued entry", tag);
        end else begin
            got = host_q4.pop_front();
            if (got.is_read) begin
                vectors++; if (if4.host_rdata !== got.data) begin miscompares++; $display("FAIL %s_rdata: got %h want %h", tag, if4.host_rdata, got.data); end
            end
        end
        vectors++; if (if4.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL %s_ack_stall: got %b want 0", tag, if4.cpu_stall); end
        if4.host_req = 0; if4.host_we = 0;
    endtask

    task automatic test_host_only();
        host_xfer4("host_write", 1'b1, 32'h10, 32'hDEADBEEF);
    endtask

    task automatic test_host_read();
        host_xfer4("host_read", 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_wait4();
        host_exp_t e;
        logic held;
        logic [31:0] exp_d;
        int a, ack_at, stalls;
        held = 0; a = 32'h20; ack_at = -1; stalls = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                if4.host_req = 1; if4.host_we = 0; if4.host_addr = 32'h10;
                e.is_read = 1; e.data = exp4[8'h10]; host_q4.push_back(e);
            end
            if (!held) begin
                if4.cpu_re = 1; if4.cpu_addr = 32'(a);
                cpu_q4.push_back(exp4[a & 255]); a++;
            end
            @(negedge clk);
            vectors++; if (if4.cpu_stall !== (i == 4)) begin miscompares++; $display("FAIL wait4_stall[%0d]: got %b want %b", i, if4.cpu_stall, (i == 4)); end
            if (i == 0) begin
                vectors++; if (if4.mem_addr !== 32'h20) begin miscompares++; $display("FAIL wait4_cpu_first: got addr=%h want 20", if4.mem_addr); end
            end
            if (i == 4) begin
                vectors++; if (if4.mem_addr !== 32'h10 || if4.mem_re !== 1'b1) begin miscompares++; $display("FAIL wait4_grant: got addr=%h re=%b want 10 1", if4.mem_addr, if4.mem_re); end
            end
            held = if4.cpu_stall;
            if (held) stalls++;
            if (!held) begin
                vectors++;
                if (cpu_q4.size() == 0) begin
                    miscompares++; $display("FAIL wait4_cpu_sb[%0d]: got empty queue want entry", i);
                end else begin
                    exp_d = cpu_q4.pop_front();
                    if (if4.cpu_rdata !== exp_d) begin miscompares++; $display("FAIL wait4_cpu_rdata[%0d]: got %h want %h", i, if4.cpu_rdata, exp_d); end
                end
            end
            if (if4.host_ack) begin
                ack_at = i;
                vectors++;
                if (host_q4.size() == 0) begin
                    miscompares++; $display("FAIL wait4_host_sb: got empty queue want entry");
                end else begin
                    e = host_q4.pop_front();
                    if (if4.host_rdata !== e.data) begin miscompares++; $display("FAIL wait4_host_rdata: got %h want %h", if4.host_rdata, e.data); end
                end
                if4.host_req = 0;
            end
        end
        @(posedge clk); #1; if4.cpu_re = 0;
        vectors++; if (ack_at != 5) begin miscompares++; $display("FAIL wait4_ack_cycle: got %0d want 5", ack_at); end
        vectors++; if (stalls != 1) begin miscompares++; $display("FAIL wait4_stall_count: got %0d want 1", stalls); end
    endtask

    task automatic test_wait0();
        host_exp_t e;
        logic held;
        logic [31:0] exp_d;
        int b, k;
        held = 0; b = 32'h80; k = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                if0.host_req = 1; if0.host_we = 0; if0.host_addr = 32'h40;
                e.is_read = 1; e.data = exp0[8'h40]; host_q0.push_back(e);
            end
            if (!held) begin
                if0.cpu_re = 1; if0.cpu_addr = 32'(b);
                cpu_q0.push_back(exp0[b & 255]); b++;
            end
            @(negedge clk);
            vectors++; if (if0.cpu_stall !== (i % 2 == 0)) begin miscompares++; $display("FAIL wait0_stall[%0d]: got %b want %b", i, if0.cpu_stall, (i % 2 == 0)); end
            vectors++; if (if0.host_ack !== (i % 2 == 1)) begin miscompares++; $display("FAIL wait0_ack[%0d]: got %b want %b", i, if0.host_ack, (i % 2 == 1)); end
            held = if0.cpu_stall;
            if (!held) begin
                vectors++;
                if (cpu_q0.size() == 0) begin
                    miscompares++; $display("FAIL wait0_cpu_sb[%0d]: got empty queue want entry", i);
                end else begin
                    exp_d = cpu_q0.pop_front();
                    if (if0.cpu_rdata !== exp_d) begin miscompares++; $display("FAIL wait0_cpu_rdata[%0d]: got %h want %h", i, if0.cpu_rdata, exp_d); end
                end
            end
            if (if0.host_ack) begin
                vectors++;
                if (host_q0.size() == 0) begin
                    miscompares++; $display("FAIL wait0_host_sb[%0d]: got empty queue want entry", i);
                end else begin
                    e = host_q0.pop_front();
                    if (if0.host_rdata !== e.data) begin miscompares++; $display("FAIL wait0_host_rdata[%0d]: got %h want %h", i, if0.host_rdata, e.data); end
                end
                k++;
                if (i < 6) begin
                    if0.host_addr = 32'h40 + 32'(k);
                    e.is_read = 1; e.data = exp0[(32'h40 + k) & 255]; host_q0.push_back(e);
                end else begin
                    if0.host_req = 0;
                end
            end
        end
        @(posedge clk); #1; if0.cpu_re = 0;
    endtask

    task automatic test_reset_in_ack();
        host_exp_t e;
        @(posedge clk); #1;
        if4.host_req = 1; if4.host_we = 1; if4.host_addr = 32'h30; if4.host_wdata = 32'hCAFEF00D;
        e.is_read = 0; e.data = 32'h0; host_q4.push_back(e);
        exp4[8'h30] = 32'hCAFEF00D;
        @(negedge clk);
        vectors++; if (if4.mem_we !== 1'b1) begin miscompares++; $display("FAIL rst_ack_grant: got mem_we=%b want 1", if4.mem_we); end
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        vectors++;
        if (if4.host_ack !== 1'b1) begin
            miscompares++; $display("FAIL rst_ack_pulse: got %b want 1", if4.host_ack);
        end else if (host_q4.size() != 0) begin
            e = host_q4.pop_front();
        end
        if4.host_req = 0; if4.host_we = 0;
        @(posedge clk); #1; reset = 1;
        @(negedge clk);
        vectors++; if (if4.host_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack_drop: got %b want 0", if4.host_ack); end
        vectors++; if (if4.host_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_ack_rdata: got %h want 0", if4.host_rdata); end
        host_xfer4("rst_retain", 1'b0, 32'h30, 32'h0);
    endtask

    task automatic test_stats();
`ifdef DMEM_ARB_STATS_EN
        int acks;
        acks = 0;
        @(posedge clk); #1; reset = 0;
        @(posedge clk); #1; reset = 1;
        if4.host_req = 1; if4.host_we = 0; if4.host_addr = 32'h10;
        for (int i = 0; i < 60 && acks < 3; i++) begin
            if4.cpu_re = 1; if4.cpu_addr = 32'h20 + 32'(i % 8);
            @(negedge clk);
            if (if4.host_ack) begin acks++; if4.host_req = 0; end
            @(posedge clk); #1;
            if (acks < 3) if4.host_req = 1;
        end
        if4.cpu_re = 0; if4.host_req = 0;
        @(negedge clk);
        vectors++; if (acks != 3) begin miscompares++; $display("FAIL stats_acks: got %0d want 3", acks); end
        vectors++; if (stall4 !== 32'd3) begin miscompares++; $display("FAIL stats_stall: got %0d want 3", stall4); end
        vectors++; if (xfer4 !== 32'd3) begin miscompares++; $display("FAIL stats_xfers: got %0d want 3", xfer4); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            exp4[i] = init_val(i);
            exp0[i] = init_val(i);
        end
        idle_all();
        test_reset();
        test_host_only();
        test_host_read();
        test_wait4();
        test_wait0();
        test_reset_in_ack();
        test_stats();
        vectors++; if (host_q4.size() != 0 || host_q0.size() != 0) begin miscompares++; $display("FAIL host_sb_drain: got %0d/%0d left want 0/0", host_q4.size(), host_q0.size()); end
        vectors++; if (cpu_q4.size() != 0 || cpu_q0.size() != 0) begin miscompares++; $display("FAIL cpu_sb_drain: got %0d/%0d left want 0/0", cpu_q4.size(), cpu_q0.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter placed between the pipeline MEM stage and `dataMem`, sharing that memory with a host/debug port used for program loading and result readback. The CPU has default priority. A bounded-wait counter guarantees the host an access slot. When the host takes the slot, the arbiter raises a combinational stall that freezes the whole pipeline for exactly that cycle.

## Interface
Parameters:
- `ADDR_W`, 32: address width, both requesters.
- `DATA_W`, 32: data width.
- `HOST_WAIT_MAX`, 4: consecutive cycles the host may lose to the CPU before it is forced in; 0 gives the host absolute priority.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low.
- `cpu_re`, `cpu_we`  in  1: MEM-stage MemRead/MemWrite.
- `cpu_addr`  in  ADDR_W: MEM-stage ALU result.
- `cpu_wdata`  in  DATA_W: store data.
- `cpu_rdata`  out  DATA_W: load data to MEM/WB.
- `cpu_stall`  out  1: freeze the pipeline this cycle.
- `host_req`  in  1: host access request, level.
- `host_we`  in  1: 1 = write.
- `host_addr`  in  ADDR_W: host address.
- `host_wdata`  in  DATA_W: host write data.
- `host_rdata`  out  DATA_W: registered read data.
- `host_ack`  out  1: one-cycle completion pulse.
- `mem_addr`  out  ADDR_W: to `dataMem` address.
- `mem_wdata`  out  DATA_W: to `dataMem` write data.
- `mem_we`, `mem_re`  out  1: to `dataMem` enables.
- `mem_rdata`  in  DATA_W: from `dataMem`, combinational read.

## Operation
- `cpu_req` = `cpu_re | cpu_we`.
- FSM has two states, `S_CPU` and `S_ACK`. Reset state is `S_CPU`.
- **S_CPU:** `host_pick = host_req & (~cpu_req | wait_cnt == HOST_WAIT_MAX)`.
  - When `host_pick` is 1:
    - mem_* signals are driven from the host inputs.
    - `cpu_stall = cpu_req`.
    - If `~host_we`, `host_rdata` captures `mem_rdata` at the clock edge.
    - `wait_cnt` is set to 0 and the next state is `S_ACK`.
  - When `host_pick` is 0:
    - mem_* signals pass through from the CPU inputs; `cpu_stall = 0`.
    - If `host_req & cpu_req`, `wait_cnt` increments, saturating at `HOST_WAIT_MAX`.
    - If `~host_req`, `wait_cnt` is set to 0.
- **S_ACK:**
  - `host_ack = 1`.
  - mem_* signals are driven by the CPU; `cpu_stall = 0`.
  - No host access occurs in this state.
  - `wait_cnt` keeps counting as in S_CPU; next state is `S_CPU`.
- **Host rules:**
  - The host holds `host_req`, `host_we`, `host_addr` and `host_wdata` stable until it sees `host_ack`.
  - In the ack cycle the host may drop `host_req` or present a new request; that request is evaluated in the following cycle.
  - The host therefore gets at most one access every 2 cycles.
- **cpu_rdata:** always equals `mem_rdata`. It is valid whenever `cpu_stall = 0`.
- **Idle memory:** with no request, mem_* pass the CPU inputs, so `mem_we = mem_re = 0`.
- **Integration:** `cpu_stall` must deassert the enable of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and must suppress `WB_RegWrite` side effects for that cycle.

## Timing
- Reset values:
  - `cpu_stall = 0`, `host_ack = 0`, `host_rdata = 0`.
  - `wait_cnt = 0`, state `S_CPU`.
  - mem_* follow the CPU inputs.
- Host latency:
  - The access happens in the grant cycle N; `host_ack` is high in N+1.
  - `host_rdata` is valid from N+1 until the next host read.
  - Best case: ack 1 cycle after `host_req` rises.
  - Worst case under continuous CPU traffic: HOST_WAIT_MAX+1 cycles.
- The CPU is stalled at most 1 cycle per host access, and never 2 cycles in a row.
- Simultaneous first request from both sides with `wait_cnt = 0 < HOST_WAIT_MAX`: the CPU wins.
- Reset asserted mid-access: the pending ack is dropped and the host must re-request. A write performed in the grant cycle stays committed.
- `cpu_stall`, `cpu_rdata` and mem_* are combinational from inputs and state. `host_ack`, `host_rdata` and `wait_cnt` are registered.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - Adds output ports `stat_stall_cycles[31:0]`, which counts cycles with `cpu_stall = 1`, and `stat_host_xfers[31:0]`, which counts `host_ack` pulses.
  - Both counters reset to 0 and wrap modulo 2^32.
- `DMEM_ARB_STATS_EN` undefined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

## Structure
- Package `dmem_arb_pkg`: state enum `arb_state_t {S_CPU, S_ACK}` and the `mem_sel_e` select encoding.
- `wait_cnt` width is `$clog2(HOST_WAIT_MAX+1)`, minimum 1.
- One sub-module, `arb_wait_counter`: saturating counter with clear and increment inputs and an `at_max` output.

## Test plan
- **Host only:** reset low for 2 cycles, then host write of 0xDEADBEEF to 0x10 with `cpu_req = 0`.
  - `mem_we = 1` in the grant cycle; `host_ack` next cycle; `cpu_stall` stays 0.
- **Host read after write:** host read of 0x10.
  - `host_rdata = 0xDEADBEEF` in the ack cycle.
- **Continuous CPU loads with host_req held, HOST_WAIT_MAX = 4:**
  - The host is granted on the 5th cycle.
  - `cpu_stall = 1` for exactly 1 cycle.
  - The CPU load completes with correct `cpu_rdata` the following cycle.
- **HOST_WAIT_MAX = 0 with simultaneous requests every cycle:**
  - Host and CPU alternate: host, ack/CPU, host, and so on.
  - `cpu_stall` pattern is 1,0,1,0.
- **Reset in ack cycle:**
  - `host_ack` goes to 0 next cycle and the state returns to `S_CPU`.
  - The written location retains its data.
- **STATS_EN build, 3 forced host accesses under CPU load:**
  - `stat_stall_cycles = 3` and `stat_host_xfers = 3`.
